// File: rtl/dm_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-port data memory.
// Port 0 is the core LSU, port 1 the debug/DMA loader; one 3-cycle access at a time.
module dm_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk_i,
    input  logic              rstN_i,

    input  logic              req0_i,
    input  logic              wr0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wrData0_i,
    input  logic [2:0]        ctrl0_i,
    output logic              ack0_o,
    output logic [DATA_W-1:0] rdData0_o,

    input  logic              req1_i,
    input  logic              wr1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wrData1_i,
    input  logic [2:0]        ctrl1_i,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdData1_o,

    output logic [ADDR_W-1:0] address_o,
    output logic [DATA_W-1:0] dataWr_o,
    output logic [2:0]        dmCtrl_o,
    output logic              dmWr_o,
    input  logic [DATA_W-1:0] dataRd_i,

    output logic              busy_o,
    output logic              gntId_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                gntId_q, gntId_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wrData_q, wrData_d;
    logic [2:0]          ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   rdData0_q, rdData0_d;
    logic [DATA_W-1:0]   rdData1_q, rdData1_d;
    logic                pick;
    logic                inAccess;

    // On a tie, round-robin favours the port that did not own the previous access.
    always_comb begin
        pick = 1'b0;
        if (req0_i && req1_i) begin
            pick = RR_EN ? ~last_q : 1'b0;
        end else if (req1_i) begin
            pick = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gntId_d   = gntId_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wrData_d  = wrData_q;
        ctrl_d    = ctrl_q;
        rdData0_d = rdData0_q;
        rdData1_d = rdData1_q;
        case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    gntId_d  = pick;
                    wr_d     = pick ? wr1_i     : wr0_i;
                    addr_d   = pick ? addr1_i   : addr0_i;
                    wrData_d = pick ? wrData1_i : wrData0_i;
                    ctrl_d   = pick ? ctrl1_i   : ctrl0_i;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (!wr_q) begin
                    if (gntId_q) begin
                        rdData1_d = dataRd_i;
                    end else begin
                        rdData0_d = dataRd_i;
                    end
                end
                last_d  = gntId_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstN_i) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gntId_q   <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wrData_q  <= '0;
            ctrl_q    <= '0;
            rdData0_q <= '0;
            rdData1_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gntId_q   <= gntId_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wrData_q  <= wrData_d;
            ctrl_q    <= ctrl_d;
            rdData0_q <= rdData0_d;
            rdData1_q <= rdData1_d;
        end
    end

    // Reset gates the write enable directly so a store caught by reset never commits.
    assign inAccess  = (state_q == ACCESS);
    assign address_o = inAccess ? addr_q   : '0;
    assign dataWr_o  = inAccess ? wrData_q : '0;
    assign dmCtrl_o  = inAccess ? ctrl_q   : 3'b000;
    assign dmWr_o    = inAccess & wr_q & rstN_i;

    assign ack0_o    = (state_q == DONE) & ~gntId_q;
    assign ack1_o    = (state_q == DONE) &  gntId_q;
    assign rdData0_o = rdData0_q;
    assign rdData1_o = rdData1_q;
    assign busy_o    = (state_q != IDLE);
    assign gntId_o   = gntId_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: a round-robin instance backed by a small word memory,
// plus a fixed-priority instance exercised with permanently contending requests.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rstN;

    logic        req0, wr0, req1, wr1;
    logic [31:0] addr0, wrData0, addr1, wrData1;
    logic [2:0]  ctrl0, ctrl1;
    logic        ack0, ack1, dmWr, busy, gntId;
    logic [31:0] rdData0, rdData1, address, dataWr, dataRd;
    logic [2:0]  dmCtrl;

    logic        fReq0, fReq1;
    logic        fAck0, fAck1, fDmWr, fBusy, fGntId;
    logic [31:0] fRdData0, fRdData1, fAddress, fDataWr;
    logic [2:0]  fDmCtrl;

    logic [31:0] memRr [0:15];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) dutRr (
        .clk_i(clk), .rstN_i(rstN),
        .req0_i(req0), .wr0_i(wr0), .addr0_i(addr0), .wrData0_i(wrData0), .ctrl0_i(ctrl0),
        .ack0_o(ack0), .rdData0_o(rdData0),
        .req1_i(req1), .wr1_i(wr1), .addr1_i(addr1), .wrData1_i(wrData1), .ctrl1_i(ctrl1),
        .ack1_o(ack1), .rdData1_o(rdData1),
        .address_o(address), .dataWr_o(dataWr), .dmCtrl_o(dmCtrl), .dmWr_o(dmWr),
        .dataRd_i(dataRd), .busy_o(busy), .gntId_o(gntId)
    );

    dm_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) dutFp (
        .clk_i(clk), .rstN_i(rstN),
        .req0_i(fReq0), .wr0_i(1'b0), .addr0_i(32'h0000_0020), .wrData0_i(32'hCAFE_0000),
        .ctrl0_i(3'b101), .ack0_o(fAck0), .rdData0_o(fRdData0),
        .req1_i(fReq1), .wr1_i(1'b0), .addr1_i(32'h0000_0024), .wrData1_i(32'hBEEF_0000),
        .ctrl1_i(3'b011), .ack1_o(fAck1), .rdData1_o(fRdData1),
        .address_o(fAddress), .dataWr_o(fDataWr), .dmCtrl_o(fDmCtrl), .dmWr_o(fDmWr),
        .dataRd_i(32'h0000_0000), .busy_o(fBusy), .gntId_o(fGntId)
    );

    // Single-port word memory with combinational read, as DataMemory behaves.
    assign dataRd = memRr[address[5:2]];
    always @(posedge clk) begin
        if (dmWr) memRr[address[5:2]] <= dataWr;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit port, input logic req, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data);
        if (port) begin
            req1 = req; wr1 = wr; addr1 = addr; wrData1 = data; ctrl1 = 3'b010;
        end else begin
            req0 = req; wr0 = wr; addr0 = addr; wrData0 = data; ctrl0 = 3'b010;
        end
    endtask

    initial begin
        rstN = 1'b0;
        fReq0 = 1'b0;
        fReq1 = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h1234_5678);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h4, 32'h8765_4321);

        // Reset held two cycles with both requests pending
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("rstAck0", 32'(ack0), 32'd0);
            checkOutput("rstAck1", 32'(ack1), 32'd0);
            checkOutput("rstDmWr", 32'(dmWr), 32'd0);
            checkOutput("rstBusy", 32'(busy), 32'd0);
        end
        checkOutput("rstGnt", 32'(gntId), 32'd0);
        checkOutput("rstRd0", rdData0, 32'h0);
        checkOutput("rstAddr", address, 32'h0);
        rstN = 1'b1;

        // Port 0 store wins the first tie
        tick();
        checkOutput("st0Busy", 32'(busy), 32'd1);
        checkOutput("st0Gnt", 32'(gntId), 32'd0);
        checkOutput("st0DmWr", 32'(dmWr), 32'd1);
        checkOutput("st0Addr", address, 32'h0);
        checkOutput("st0Data", dataWr, 32'h1234_5678);
        checkOutput("st0Ctrl", 32'(dmCtrl), 32'd2);
        checkOutput("st0AckEarly", 32'(ack0), 32'd0);
        tick();
        checkOutput("st0Ack", 32'(ack0), 32'd1);
        checkOutput("st0Ack1", 32'(ack1), 32'd0);
        checkOutput("st0DoneDmWr", 32'(dmWr), 32'd0);
        checkOutput("st0DoneAddr", address, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("idle1Busy", 32'(busy), 32'd0);
        checkOutput("idle1Ack0", 32'(ack0), 32'd0);

        // Port 1 store wins the next tie
        tick();
        checkOutput("st1Gnt", 32'(gntId), 32'd1);
        checkOutput("st1DmWr", 32'(dmWr), 32'd1);
        checkOutput("st1Addr", address, 32'h4);
        checkOutput("st1Data", dataWr, 32'h8765_4321);
        tick();
        checkOutput("st1Ack", 32'(ack1), 32'd1);
        checkOutput("st1Ack0", 32'(ack0), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
        tick();

        // Port 0 load of 0x0
        tick();
        checkOutput("ld0Gnt", 32'(gntId), 32'd0);
        checkOutput("ld0DmWr", 32'(dmWr), 32'd0);
        checkOutput("ld0RdEarly", rdData0, 32'h0);
        tick();
        checkOutput("ld0Ack", 32'(ack0), 32'd1);
        checkOutput("ld0Data", rdData0, 32'h1234_5678);
        checkOutput("ld0Rd1", rdData1, 32'h0);
        req0 = 1'b0;
        tick();

        // Port 1 load of 0x4
        tick();
        checkOutput("ld1Gnt", 32'(gntId), 32'd1);
        tick();
        checkOutput("ld1Ack", 32'(ack1), 32'd1);
        checkOutput("ld1Data", rdData1, 32'h8765_4321);
        checkOutput("ld1Rd0Held", rdData0, 32'h1234_5678);
        req1 = 1'b0;
        tick();
        checkOutput("idle2Busy", 32'(busy), 32'd0);

        // Early drop: port 1 store with request fields changed during ACCESS
        applyStimulus(1'b1, 1'b1, 1'b1, 32'hC, 32'h55AA_55AA);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
        #1;
        checkOutput("dropAddr", address, 32'hC);
        checkOutput("dropData", dataWr, 32'h55AA_55AA);
        checkOutput("dropDmWr", 32'(dmWr), 32'd1);
        tick();
        checkOutput("dropAck", 32'(ack1), 32'd1);
        checkOutput("dropRd1", rdData1, 32'h8765_4321);
        tick();
        checkOutput("dropAckOnce", 32'(ack1), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'hC, 32'h0);
        tick();
        tick();
        checkOutput("dropLdAck", 32'(ack0), 32'd1);
        checkOutput("dropLdData", rdData0, 32'h55AA_55AA);

        // Reset during a store: old contents of 0x8 survive
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h8, 32'hA5A5_A5A5);
        tick();
        tick();
        tick();
        checkOutput("preAck", 32'(ack0), 32'd1);
        req0 = 1'b0;
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF);
        tick();
        checkOutput("midDmWrPre", 32'(dmWr), 32'd1);
        rstN = 1'b0;
        req0 = 1'b0;
        #1;
        checkOutput("midDmWr", 32'(dmWr), 32'd0);
        tick();
        checkOutput("midBusy", 32'(busy), 32'd0);
        checkOutput("midAck", 32'(ack0), 32'd0);
        rstN = 1'b1;
        tick();
        checkOutput("midNoAck", 32'(ack0), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
        tick();
        tick();
        checkOutput("midLdAck", 32'(ack0), 32'd1);
        checkOutput("midLdData", rdData0, 32'hA5A5_A5A5);
        req0 = 1'b0;
        tick();

        // Fixed priority: port 0 takes every access while both request
        fReq0 = 1'b1;
        fReq1 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checkOutput("fpAck1", 32'(fAck1), 32'd0);
            checkOutput("fpAck0", 32'(fAck0), (k % 3 == 2) ? 32'd1 : 32'd0);
            checkOutput("fpDmWr", 32'(fDmWr), 32'd0);
            if (k % 3 == 1) begin
                checkOutput("fpGnt", 32'(fGntId), 32'd0);
                checkOutput("fpBusy", 32'(fBusy), 32'd1);
                checkOutput("fpAddr", fAddress, 32'h20);
                checkOutput("fpData", fDataWr, 32'hCAFE_0000);
                checkOutput("fpCtrl", 32'(fDmCtrl), 32'd5);
            end
        end
        checkOutput("fpRd0", fRdData0, 32'h0);
        checkOutput("fpRd1", fRdData1, 32'h0);
        fReq0 = 1'b0;
        fReq1 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
